// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage: PC, imem requests, IF/ID buffer
// Single outstanding request; responses land in a shift buffer whose entry 0 drives decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam logic [3:0] DEPTH = 4'(BUF_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        outst_q, outst_d;
  logic        drop_q, drop_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] inst_q [BUF_DEPTH];
  logic [31:0] inst_d [BUF_DEPTH];
  logic [31:0] bpc_q  [BUF_DEPTH];
  logic [31:0] bpc_d  [BUF_DEPTH];

  logic        pop;
  logic        push;
  logic        accept;
  logic [2:0]  wr_idx;
  logic [3:0]  occupancy;

  assign if_valid  = (count_q != 3'd0);
  assign if_inst   = if_valid ? inst_q[0] : NOP_INST;
  assign if_pc     = bpc_q[0];
  assign if_pc4    = bpc_q[0] + 32'd4;
  assign imem_addr = pc_q;

  // Occupancy counts the in-flight word so a full buffer can never be overrun.
  assign pop       = if_valid && !id_stall;
  assign occupancy = {1'b0, count_q} + {3'b000, outst_q} - {3'b000, pop};
  assign imem_req  = !rst && !redirect && (!outst_q || imem_rvalid) && (occupancy < DEPTH);
  assign accept    = imem_req && imem_ready;
  assign push      = imem_rvalid && !drop_q && !redirect;

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    count_d  = count_q;
    inst_d   = inst_q;
    bpc_d    = bpc_q;
    wr_idx   = count_q;

    if (accept) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
      outst_d  = 1'b1;
    end else if (imem_rvalid) begin
      outst_d  = 1'b0;
    end

    if (imem_rvalid) begin
      drop_d = 1'b0;
    end

    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 3'd0;
      // The in-flight word belongs to the old path; swallow it when it arrives.
      if (outst_q && !imem_rvalid) begin
        drop_d = 1'b1;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          inst_d[i] = inst_q[i+1];
          bpc_d[i]  = bpc_q[i+1];
        end
        wr_idx = count_q - 3'd1;
      end
      if (push) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (3'(i) == wr_idx) begin
            inst_d[i] = imem_rdata;
            bpc_d[i]  = req_pc_q;
          end
        end
      end
      count_d = wr_idx + {2'b00, push};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      outst_q  <= 1'b0;
      drop_q   <= 1'b0;
      count_q  <= 3'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_q[i] <= NOP_INST;
        bpc_q[i]  <= RESET_PC;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      inst_q   <= inst_d;
      bpc_q    <= bpc_d;
    end
  end

  rvalid_needs_request: assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> outst_q);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with an in-order single-outstanding imem model
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // memory model state
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat;

  // reference model of request address and delivered instruction stream
  logic [31:0] exp_addr;
  logic [31:0] exp_pc;
  int          n_pops;
  logic        saw_wrap;
  logic        saw_pc4_wrap;

  logic        c_req, c_acc, c_vld, c_rv;
  logic [31:0] c_addr, c_pc, c_pc4, c_inst;

  // One clock: called at negedge with inputs already set, returns at the next negedge.
  task automatic cycle();
    imem_rvalid = mem_pend && (mem_cnt == 1);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    #1;
    c_req  = imem_req;
    c_addr = imem_addr;
    c_acc  = imem_req && imem_ready;
    c_rv   = imem_rvalid;
    c_vld  = if_valid;
    c_pc   = if_pc;
    c_pc4  = if_pc4;
    c_inst = if_inst;
    if (c_req) check("req_addr", c_addr, exp_addr);
    if (c_vld && !id_stall && !redirect) begin
      check("pop_pc", c_pc, exp_pc);
      check("pop_inst", c_inst, mem_word(exp_pc));
      check("pop_pc4", c_pc4, exp_pc + 32'd4);
      if (exp_pc == 32'hFFFF_FFFC) saw_pc4_wrap = 1'b1;
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    @(posedge clk);
    if (c_rv) mem_pend = 1'b0;
    if (c_acc) begin
      if (exp_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      mem_pend = 1'b1;
      mem_cnt  = lat;
      mem_addr = exp_addr;
      exp_addr = exp_addr + 32'd4;
    end else if (mem_pend) begin
      mem_cnt--;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  n0;
    logic found;
    rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0; lat = 1;
    exp_addr = RESET_PC; exp_pc = RESET_PC; n_pops = 0;
    saw_wrap = 1'b0; saw_pc4_wrap = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, RESET_PC);
    check("rst_pc4", if_pc4, RESET_PC + 32'd4);
    rst = 1'b0;

    // back-to-back stream, first if_valid two cycles after first accept
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i < 3) check("t1_req", 32'(c_req), 32'd1);
      check("t1_valid", 32'(c_vld), 32'(i >= 2));
    end

    // decode stall: head frozen, issue blocked once full, no loss afterwards
    repeat (3) cycle();
    id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t2_stall_vld", 32'(c_vld), 32'd1);
      check("t2_stall_pc", c_pc, exp_pc);
      check("t2_stall_inst", c_inst, mem_word(exp_pc));
      if (i >= 1) check("t2_full_req", 32'(c_req), 32'd0);
    end
    id_stall = 1'b0;
    n0 = n_pops;
    repeat (6) cycle();
    check("t2_resume_pops", 32'(n_pops - n0), 32'd6);

    // redirect with a request in flight whose response comes later
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_pend && mem_cnt > 1) found = 1'b1;
      else cycle();
    end
    check("t3_found_outstanding", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    exp_addr = 32'h0000_0100; exp_pc = 32'h0000_0100;
    cycle();
    check("t3_redir_req", 32'(c_req), 32'd0);
    redirect = 1'b0;
    cycle();
    check("t3_flush_valid", 32'(c_vld), 32'd0);
    check("t3_flush_inst", c_inst, NOP);
    n0 = n_pops;
    repeat (12) cycle();
    check("t3_progress", 32'(n_pops > n0), 32'd1);

    // redirect coinciding with rvalid and stall
    lat = 1;
    repeat (4) cycle();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_pend && mem_cnt == 1) found = 1'b1;
      else cycle();
    end
    check("t4_found_rvalid", 32'(found), 32'd1);
    id_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    exp_addr = 32'h0000_0200; exp_pc = 32'h0000_0200;
    cycle();
    check("t4_redir_req", 32'(c_req), 32'd0);
    redirect = 1'b0;
    cycle();
    check("t4_flush_valid", 32'(c_vld), 32'd0);
    check("t4_flush_inst", c_inst, NOP);
    check("t4_restart_req", 32'(c_req), 32'd1);
    id_stall = 1'b0;
    n0 = n_pops;
    repeat (8) cycle();
    check("t4_progress", 32'(n_pops > n0), 32'd1);

    // memory not ready, then slow responses
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_req_held", 32'(c_req), 32'd1);
    end
    imem_ready = 1'b1; lat = 4;
    n0 = n_pops;
    repeat (20) cycle();
    check("t5_progress", 32'(n_pops > n0), 32'd1);

    // PC wrap at the top of the address space
    lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    exp_addr = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();
    check("t6_wrap_req", 32'(saw_wrap), 32'd1);
    check("t6_wrap_pc4", 32'(saw_pc4_wrap), 32'd1);

    // asynchronous reset in the middle of a transaction
    lat = 3;
    repeat (2) cycle();
    rst = 1'b1; imem_rvalid = 1'b0;
    #1;
    check("t7_rst_req", 32'(imem_req), 32'd0);
    check("t7_rst_valid", 32'(if_valid), 32'd0);
    check("t7_rst_inst", if_inst, NOP);
    check("t7_rst_pc", if_pc, RESET_PC);
    check("t7_rst_pc4", if_pc4, RESET_PC + 32'd4);
    mem_pend = 1'b0; exp_addr = RESET_PC; exp_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b0; lat = 1;
    n0 = n_pops;
    repeat (5) cycle();
    check("t7_restart_pops", 32'(n_pops - n0), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
